// File: rtl/iobuf_bank_pkg.sv
// Shared constants for the bidirectional pad bank: parameter defaults,
// legal ranges and the glitch-filter counter width.
package iobuf_bank_pkg;

    localparam int unsigned WIDTH_DEF         = 8;
    localparam int unsigned WIDTH_MIN         = 1;
    localparam int unsigned WIDTH_MAX         = 64;

    localparam int unsigned SYNC_STAGES_DEF   = 2;
    localparam int unsigned SYNC_STAGES_MIN   = 2;
    localparam int unsigned SYNC_STAGES_MAX   = 4;

    localparam int unsigned FILTER_CYCLES_DEF = 4;
    localparam int unsigned FILTER_CYCLES_MIN = 1;
    localparam int unsigned FILTER_CYCLES_MAX = 255;

    // Bits needed for a counter that can hold 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/iobuf_bank_chan.sv
// One pad channel: registered output drive and enable, tristate pad,
// input synchroniser, optional glitch filter, rise/fall edge pulses.
// Optional feature: IOBUF_BANK_FILTER_EN compiles in the glitch filter.
module iobuf_bank_chan
    import iobuf_bank_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
`ifdef IOBUF_BANK_FILTER_EN
    , parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic datain,
    input  logic oe,
    inout  wire  pad,
    output logic dataout,
    output logic rise,
    output logic fall
);

    logic                   dout_q;
    logic                   oe_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic                   prev_q;

    // Output drive and enable captured together so the pad never shows a mixed state.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= 1'b0;
            oe_q   <= 1'b0;
        end else begin
            dout_q <= datain;
            oe_q   <= oe;
        end
    end

    assign pad = oe_q ? dout_q : 1'bz;

    // Synchroniser chain; the pad is sampled even while we drive it (loopback).
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef IOBUF_BANK_FILTER_EN
    localparam int unsigned CW = cnt_width(FILTER_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          dout_d;

    // Filter next state: count disagreeing cycles, accept the new level on the last one.
    always_comb begin
        cnt_d  = '0;
        dout_d = dataout;
        if (sync_bit != dataout) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                dout_d = sync_bit;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            dataout <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dataout <= dout_d;
        end
    end
`else
    // Unfiltered: one register stage behind the synchroniser.
    always_ff @(posedge clock) begin
        if (reset) begin
            dataout <= 1'b0;
        end else begin
            dataout <= sync_bit;
        end
    end
`endif

    // Previous dataout for edge detection; cleared by reset so no pulse follows it.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= dataout;
        end
    end

    assign rise = dataout & ~prev_q;
    assign fall = ~dataout & prev_q;

endmodule

// File: rtl/iobuf_bank.sv
// Bank of WIDTH independent bidirectional pad channels.
// Optional feature: IOBUF_BANK_FILTER_EN compiles in a per-channel glitch
// filter of FILTER_CYCLES cycles; without it FILTER_CYCLES is only range-checked.
module iobuf_bank
    import iobuf_bank_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] datain,
    input  logic [WIDTH-1:0] oe,
    output logic [WIDTH-1:0] dataout,
    inout  wire  [WIDTH-1:0] padio,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Reject illegal configurations at elaboration.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("iobuf_bank: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("iobuf_bank: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end
    if (FILTER_CYCLES < FILTER_CYCLES_MIN || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filt
        $error("iobuf_bank: FILTER_CYCLES=%0d outside %0d..%0d",
               FILTER_CYCLES, FILTER_CYCLES_MIN, FILTER_CYCLES_MAX);
    end

    // One fully independent channel per pad.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
        iobuf_bank_chan #(
            .SYNC_STAGES   (SYNC_STAGES)
`ifdef IOBUF_BANK_FILTER_EN
            , .FILTER_CYCLES (FILTER_CYCLES)
`endif
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .datain  (datain[i]),
            .oe      (oe[i]),
            .pad     (padio[i]),
            .dataout (dataout[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule

// File: tb/tb_iobuf_bank.sv
// Self-checking bench for iobuf_bank: directed vector table, latency and
// reset corner sequences, then randomized traffic against a reference model.
module tb_iobuf_bank;

    localparam int W = 64;
    localparam int S = 2;
    localparam int F = 4;
`ifdef IOBUF_BANK_FILTER_EN
    localparam int LAT = S + F;
`else
    localparam int LAT = S + 1;
`endif
    localparam logic [W-1:0] EVEN = 64'h5555_5555_5555_5555;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] datain;
    logic [W-1:0] oe;
    logic [W-1:0] dataout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    wire  [W-1:0] padio;

    // External device on the pads: drives wherever the DUT has released.
    logic [W-1:0] tb_en;
    logic [W-1:0] tb_val;

    for (genvar g = 0; g < W; g++) begin : g_ext
        assign padio[g] = tb_en[g] ? tb_val[g] : 1'bz;
    end

    always #5 clock = ~clock;

    iobuf_bank #(
        .WIDTH         (W),
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .datain  (datain),
        .oe      (oe),
        .dataout (dataout),
        .padio   (padio),
        .rise    (rise),
        .fall    (fall)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [W-1:0] m_oe, m_dq, m_sync, m_dout, m_prev;
    int           m_run [W];
    logic [W-1:0] hpad [8];
    bit           hrst [8];
    int           t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of one rising edge: pad seen S edges ago (lost if any reset since),
    // optional filter on disagreement runs, and output registers.
    task automatic model_edge();
        logic [W-1:0] pad, sync_new, dnext;
        bit ok;
        pad = (m_oe & m_dq) | (~m_oe & tb_val);
        t++;
        hpad[3'(t % 8)] = pad;
        hrst[3'(t % 8)] = reset;
        ok = 1'b1;
        for (int j = 0; j < S; j++) if (hrst[3'((t - j) % 8)]) ok = 1'b0;
        sync_new = ok ? hpad[3'((t - S + 1) % 8)] : '0;
        if (reset) begin
            dnext = '0;
            for (int c = 0; c < W; c++) m_run[c] = 0;
        end else begin
`ifdef IOBUF_BANK_FILTER_EN
            dnext = m_dout;
            for (int c = 0; c < W; c++) begin
                if (m_sync[c] == m_dout[c]) m_run[c] = 0;
                else begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == F) begin
                        dnext[c] = m_sync[c];
                        m_run[c] = 0;
                    end
                end
            end
`else
            dnext = m_sync;
`endif
        end
        m_prev = reset ? '0 : m_dout;
        m_dout = dnext;
        m_sync = sync_new;
        m_oe   = reset ? '0 : oe;
        m_dq   = reset ? '0 : datain;
    endtask

    // Apply current inputs across one clock edge and compare everything.
    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
        tb_en = ~m_oe;
        @(negedge clock);
        check("dataout", dataout, m_dout);
        check("rise", rise, m_dout & ~m_prev);
        check("fall", fall, ~m_dout & m_prev);
        check("padio", padio, (m_oe & m_dq) | (~m_oe & tb_val));
    endtask

    task automatic idle_reset(input int settle);
        reset = 1'b1; oe = '0; datain = '0; tb_val = '0;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < settle; k++) cycle();
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] oe;
        logic [7:0] din;
        logic [7:0] ext;
        logic [7:0] exp_pad;
    } vec_t;

    vec_t tbl [12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int first_dout, rise_at, nrise, acc;
        logic [W-1:0] exp_r, exp_f;

        tbl[0]  = '{1'b1, 8'hFF, 8'hA5, 8'h3C, 8'h3C};
        tbl[1]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 8'hFF, 8'hA5, 8'h00, 8'hA5};
        tbl[3]  = '{1'b0, 8'h00, 8'hA5, 8'h5A, 8'h5A};
        tbl[4]  = '{1'b0, 8'h0F, 8'h33, 8'hC3, 8'hC3};
        tbl[5]  = '{1'b0, 8'hF0, 8'h33, 8'h0C, 8'h3C};
        tbl[6]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        tbl[8]  = '{1'b0, 8'hAA, 8'hFF, 8'h00, 8'hAA};
        tbl[9]  = '{1'b0, 8'h55, 8'h00, 8'hFF, 8'hAA};
        tbl[10] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 8'hFF, 8'h5A, 8'h00, 8'h5A};

        m_oe = '0; m_dq = '0; m_sync = '0; m_dout = '0; m_prev = '0;
        for (int c = 0; c < W; c++) m_run[c] = 0;
        for (int j = 0; j < 8; j++) begin hpad[j] = '0; hrst[j] = 1'b1; end
        t = 8;
        reset = 1'b1; oe = '0; datain = '0; tb_val = '0; tb_en = '1;
        @(negedge clock);

        // Output path vectors; input path checked by the model every cycle.
        for (int i = 0; i < 12; i++) begin
            reset  = tbl[i].rst;
            oe     = W'(tbl[i].oe);
            datain = W'(tbl[i].din);
            tb_val = W'(tbl[i].ext);
            cycle();
            check("table_pad", W'(padio[7:0]), W'(tbl[i].exp_pad));
        end

        // Pad 0 rising: dataout and a single rise exactly LAT cycles later.
        idle_reset(LAT + 2);
        tb_val[0] = 1'b1;
        first_dout = 0; rise_at = 0; nrise = 0;
        for (int k = 1; k <= LAT + 4; k++) begin
            cycle();
            if (dataout[0] && first_dout == 0) first_dout = k;
            if (rise[0]) begin nrise++; rise_at = k; end
        end
        check("latency_dout", W'(first_dout), W'(LAT));
        check("latency_rise", W'(rise_at), W'(LAT));
        check("rise_count", W'(nrise), W'(1));

`ifdef IOBUF_BANK_FILTER_EN
        // Glitch one cycle shorter than the filter never reaches dataout.
        idle_reset(LAT + 2);
        acc = 0;
        tb_val[3] = 1'b1;
        for (int k = 0; k < F - 1; k++) begin
            cycle();
            acc = acc | int'(dataout[3] | rise[3] | fall[3]);
        end
        tb_val[3] = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            cycle();
            acc = acc | int'(dataout[3] | rise[3] | fall[3]);
        end
        check("glitch_quiet", W'(acc), W'(0));
`endif

        // Pad 5 held high, reset mid-way: full latency counted from deassertion.
        idle_reset(LAT + 2);
        tb_val[5] = 1'b1;
        for (int k = 0; k < S + 2; k++) cycle();
        reset = 1'b1;
        acc = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            acc = acc | int'(dataout[5] | rise[5] | fall[5]);
        end
        check("reset_clears", W'(acc), W'(0));
        reset = 1'b0;
        first_dout = 0; rise_at = 0; nrise = 0;
        for (int k = 1; k <= LAT + 4; k++) begin
            cycle();
            if (dataout[5] && first_dout == 0) first_dout = k;
            if (rise[5]) begin nrise++; rise_at = k; end
        end
        check("post_reset_dout", W'(first_dout), W'(LAT));
        check("post_reset_rise", W'(rise_at), W'(LAT));
        check("post_reset_count", W'(nrise), W'(1));

        // Even channels toggle together; odd stay silent, evens pulse in lockstep.
        idle_reset(LAT + 2);
        for (int n = 0; n < 6 * (LAT + 2); n++) begin
            if (n % (LAT + 2) == 0) tb_val = tb_val ^ EVEN;
            cycle();
            exp_r = '0; exp_f = '0;
            if (n % (LAT + 2) == LAT - 1) begin
                if ((n / (LAT + 2)) % 2 == 0) exp_r = EVEN;
                else exp_f = EVEN;
            end
            check("even_rise", rise, exp_r);
            check("even_fall", fall, exp_f);
        end

        // Randomized traffic: loopback on low byte, sparse pad toggles, rare resets.
        idle_reset(2);
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 49) == 0);
            oe     = W'($urandom_range(0, 255));
            datain = {$urandom, $urandom};
            tb_val = tb_val ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iobuf_bank.md
IOBUF_BANK -- requirements
Module: iobuf_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent pad channels (legal 1..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..4).
REQ-003 SHALL have parameter FILTER_CYCLES, default 4, glitch-filter stability length in cycles (legal 1..255; used only with filter compiled in).
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port datain, input, WIDTH, core value to drive on each pad.
REQ-007 SHALL have port oe, input, WIDTH, per-channel output enable (1 = drive pad).
REQ-008 SHALL have port dataout, output, WIDTH, synchronised (and filtered) pad value to core.
REQ-009 SHALL have port padio, inout, WIDTH, bidirectional pad.
REQ-010 SHALL have port rise, output, WIDTH, one-cycle pulse on dataout 0->1.
REQ-011 SHALL have port fall, output, WIDTH, one-cycle pulse on dataout 1->0.

Function
REQ-012 Output path SHALL register datain and oe once (dout_q, oe_q); pad reflects inputs 1 cycle after the capturing edge.
REQ-013 padio[i] SHALL be driven with dout_q[i] when oe_q[i]=1, high-impedance otherwise.
REQ-014 Input path SHALL pass padio[i] through SYNC_STAGES flops; the last stage is sync[i].
REQ-015 Without filter, dataout[i] SHALL be registered from sync[i]; pad-to-dataout latency = SYNC_STAGES+1 cycles.
REQ-016 With filter, per-channel counter SHALL clear when sync[i]==dataout[i] and increment when they differ.
REQ-017 With filter, dataout[i] SHALL take sync[i] (counter clears) on the edge at which sync[i] has differed from dataout[i] for FILTER_CYCLES consecutive cycles; latency = SYNC_STAGES+FILTER_CYCLES.
REQ-018 With filter, a pad pulse shorter than FILTER_CYCLES cycles SHALL never change dataout.
REQ-019 Counter SHALL saturate-free: width clog2(FILTER_CYCLES+1), never exceeds FILTER_CYCLES.
REQ-020 rise[i] SHALL equal dataout[i] & ~prev[i], fall[i] SHALL equal ~dataout[i] & prev[i], prev = dataout delayed one cycle; each pulse exactly 1 cycle.
REQ-021 Channels SHALL be fully independent; activity on one SHALL not affect another's timing.
REQ-022 While oe_q[i]=1 the input path SHALL sample the pad normally (loopback of driven value is intended).
REQ-023 Simultaneous oe and datain change SHALL take effect on the same edge (no intermediate pad state).

Reset
REQ-024 reset SHALL clear dout_q, oe_q (all pads tri-stated), all sync flops, dataout, prev, counters; rise=fall=0.
REQ-025 reset mid-filter SHALL discard partial counts; no rise/fall pulse SHALL be generated during or on the cycle after reset.
REQ-026 A pad held at 1 through reset SHALL produce one rise pulse exactly latency cycles after reset deasserts.

Configuration
REQ-027 Macro IOBUF_BANK_FILTER_EN defined: glitch filter per REQ-016..019 compiled in.
REQ-028 Macro IOBUF_BANK_FILTER_EN undefined: no counters exist, FILTER_CYCLES ignored, behaviour per REQ-015.

Structure
REQ-029 Package iobuf_bank_pkg SHALL hold parameter defaults, legal ranges and the counter-width constant function.
REQ-030 Sub-module iobuf_bank_chan SHALL implement one channel (output regs, tristate, synchroniser, filter, edge detect), instantiated WIDTH times by generate.
REQ-031 Top SHALL check parameter legality at elaboration and fail on out-of-range values.

Verification
REQ-032 reset then oe=0xFF,datain=0xA5 -> padio=0xA5 one cycle later; oe=0x00 -> padio all Z next cycle.
REQ-033 No filter, SYNC_STAGES=2, pad[0] 0->1 -> dataout[0]=1 after 3 cycles, rise[0] single pulse that cycle.
REQ-034 Filter, FILTER_CYCLES=4, pad[3] high 3 cycles -> dataout unchanged, no pulse; high 4+ cycles -> dataout[3]=1 after 6 cycles, one rise.
REQ-035 Filter, reset asserted after 2 of 4 stable cycles -> counters/dataout 0, restart requires full 4 cycles after reset.
REQ-036 WIDTH=64, alternating pad toggles on even channels only -> odd channels never pulse, even channels pulse at identical latency.
REQ-037 Pad held 1 during reset, no filter -> dataout=1 and one rise exactly 3 cycles after reset deasserts.
